// File: rtl/rf_param_if.sv
// ============================================================================
// Module      : rf_param_if
// Description : Read/write/clear bus for the rf_param register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_param_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic [AW-1:0] read_rega;
    logic [AW-1:0] read_regb;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic          rf_we;
    logic          switch;
    logic          clr;
    logic [DW-1:0] rsa;
    logic [DW-1:0] rsb;
    logic          busy;

    modport master (
        output read_rega, read_regb, write_reg, write_data, rf_we, switch, clr,
        input  rsa, rsb, busy
    );

    modport slave (
        input  read_rega, read_regb, write_reg, write_data, rf_we, switch, clr,
        output rsa, rsb, busy
    );
endinterface

`default_nettype wire

// File: rtl/rf_param.sv
// ============================================================================
// Module      : rf_param
// Description : Parametrised 2R/1W register file with a sequential clear
//               engine. Define RF_BYPASS_EN for write-first read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_param #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    rf_param_if.slave   bus
);
    localparam int            DEPTH   = 2 ** AW;
    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_CLEAR = 1'b1;
    localparam logic [AW-1:0] C_ZERO  = '0;
    localparam logic [AW-1:0] C_ONE   = AW'(1);
    localparam logic [AW-1:0] C_LAST  = AW'(DEPTH - 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [0:0]    r_state;
    logic [0:0]    w_state_next;
    logic [AW-1:0] r_cptr;
    logic [AW-1:0] w_cptr_next;
    logic [DW-1:0] r_rsa;
    logic [DW-1:0] r_rsb;
    logic          w_busy;
    logic          w_we_ok;
    logic          w_byp_a;
    logic          w_byp_b;
    logic [AW-1:0] w_ea;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cptr  <= C_ZERO;
        end else begin
            r_state <= w_state_next;
            r_cptr  <= w_cptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cptr_next  = r_cptr;
        case (r_state)
            S_CLEAR: begin
                w_cptr_next = r_cptr + C_ONE;
                if (r_cptr == C_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.clr) begin
                    w_state_next = S_CLEAR;
                    w_cptr_next  = C_ZERO;
                end
            end
        endcase
    end

    always_comb begin
        w_busy  = (r_state == S_CLEAR);
        w_we_ok = !w_busy && bus.rf_we && (bus.write_reg != C_ZERO);
        w_ea    = bus.switch ? bus.read_regb : bus.read_rega;
`ifdef RF_BYPASS_EN
        w_byp_a = w_we_ok && (bus.write_reg == w_ea);
        w_byp_b = w_we_ok && (bus.write_reg == bus.read_regb);
`else
        w_byp_a = 1'b0;
        w_byp_b = 1'b0;
`endif
    end

    // Storage is left untouched while rst is held; the clear engine runs after.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_busy) begin
                r_mem[r_cptr] <= '0;
            end else if (w_we_ok) begin
                r_mem[bus.write_reg] <= bus.write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsa <= '0;
            r_rsb <= '0;
        end else begin
            if (w_busy || (w_ea == C_ZERO)) begin
                r_rsa <= '0;
            end else if (w_byp_a) begin
                r_rsa <= bus.write_data;
            end else begin
                r_rsa <= r_mem[w_ea];
            end

            if (w_busy || (bus.read_regb == C_ZERO)) begin
                r_rsb <= '0;
            end else if (w_byp_b) begin
                r_rsb <= bus.write_data;
            end else begin
                r_rsb <= r_mem[bus.read_regb];
            end
        end
    end

    assign bus.rsa  = r_rsa;
    assign bus.rsb  = r_rsb;
    assign bus.busy = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_rf_param.sv
// ============================================================================
// Module      : tb_rf_param
// Description : Self-checking bench for rf_param (32x16 and 8x8 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_param;
    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    always #5 clk = ~clk;

    rf_param_if #(.DW(32), .AW(4)) rf ();
    rf_param_if #(.DW(8),  .AW(3)) rfs ();

    rf_param #(.DW(32), .AW(4)) dut   (.clk(clk), .rst(rst),   .bus(rf));
    rf_param #(.DW(8),  .AW(3)) dut_s (.clk(clk), .rst(rst_s), .bus(rfs));

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] mem [16];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rf.read_rega = '0; rf.read_regb = '0; rf.write_reg = '0;
        rf.write_data = '0; rf.rf_we = 1'b0; rf.switch = 1'b0; rf.clr = 1'b0;
    endtask

    task automatic model_clear;
        for (int i = 0; i < 16; i++) mem[i] = '0;
    endtask

    // Value a read port should latch given the current stored contents and the
    // write presented on the same edge.
    function automatic logic [31:0] model_read(input logic [3:0] addr, input logic we,
                                               input logic [3:0] wreg, input logic [31:0] wdata);
        if (addr == 4'd0) return 32'd0;
        if (BYPASS && we && wreg != 4'd0 && wreg == addr) return wdata;
        return mem[addr];
    endfunction

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data);
        rf.rf_we = 1'b1; rf.write_reg = addr; rf.write_data = data;
        step();
        rf.rf_we = 1'b0;
        if (addr != 4'd0) mem[addr] = data;
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        step(); step();
        n_total++;
        if (rf.busy !== 1'b1 || rf.rsa !== 32'd0 || rf.rsb !== 32'd0) begin
            $display("FAIL reset_state busy=%b rsa=%h rsb=%h required busy=1 rsa=0 rsb=0", rf.busy, rf.rsa, rf.rsb);
        end else n_pass++;
        rst = 1'b0;
        rf.read_rega = 4'd5; rf.read_regb = 4'd5;
        n = 0;
        while (1) begin
            if (n == 9) begin
                rf.rf_we = 1'b1; rf.write_reg = 4'd3; rf.write_data = 32'hFFFF_FFFF;
            end else rf.rf_we = 1'b0;
            step();
            n++;
            n_total++;
            if (rf.rsa !== 32'd0) $display("FAIL reset_busy_read clk=%0d rsa=%h required 0", n, rf.rsa);
            else n_pass++;
            if (rf.busy !== 1'b1 || n >= 100) break;
        end
        rf.rf_we = 1'b0;
        model_clear();
        n_total++;
        if (n != 16) $display("FAIL reset_clear_len got %0d clocks required 16", n);
        else n_pass++;
        rf.read_rega = 4'd3; rf.read_regb = 4'd3;
        step();
        n_total++;
        if (rf.rsa !== 32'd0 || rf.rsb !== 32'd0)
            $display("FAIL reset_r3_ignored rsa=%h rsb=%h required 0", rf.rsa, rf.rsb);
        else n_pass++;
    endtask

    task automatic test_basic_rw;
        do_write(4'd7, 32'hDEAD_BEEF);
        rf.read_rega = 4'd7; rf.read_regb = 4'd7;
        step();
        n_total++;
        if (rf.rsa !== 32'hDEAD_BEEF || rf.rsb !== 32'hDEAD_BEEF)
            $display("FAIL basic_r7 rsa=%h rsb=%h required deadbeef", rf.rsa, rf.rsb);
        else n_pass++;
        do_write(4'd0, 32'h1234);
        rf.read_rega = 4'd0; rf.read_regb = 4'd0;
        step();
        n_total++;
        if (rf.rsa !== 32'd0 || rf.rsb !== 32'd0)
            $display("FAIL basic_r0 rsa=%h rsb=%h required 0", rf.rsa, rf.rsb);
        else n_pass++;
    endtask

    task automatic test_switch;
        do_write(4'd2, 32'h11);
        do_write(4'd9, 32'h99);
        rf.read_rega = 4'd2; rf.read_regb = 4'd9; rf.switch = 1'b1;
        step();
        n_total++;
        if (rf.rsa !== 32'h99 || rf.rsb !== 32'h99)
            $display("FAIL switch_r9 rsa=%h rsb=%h required 99", rf.rsa, rf.rsb);
        else n_pass++;
        rf.read_regb = 4'd0;
        step();
        n_total++;
        if (rf.rsa !== 32'd0 || rf.rsb !== 32'd0)
            $display("FAIL switch_r0 rsa=%h rsb=%h required 0", rf.rsa, rf.rsb);
        else n_pass++;
        rf.switch = 1'b0;
    endtask

    task automatic test_bypass;
        logic [31:0] exp;
        do_write(4'd4, 32'hA);
        exp = BYPASS ? 32'hB : 32'hA;
        rf.read_rega = 4'd4; rf.read_regb = 4'd4;
        do_write(4'd4, 32'hB);
        n_total++;
        if (rf.rsa !== exp || rf.rsb !== exp)
            $display("FAIL bypass_same_edge rsa=%h rsb=%h required %h", rf.rsa, rf.rsb, exp);
        else n_pass++;
        step();
        n_total++;
        if (rf.rsa !== 32'hB || rf.rsb !== 32'hB)
            $display("FAIL bypass_next rsa=%h rsb=%h required b", rf.rsa, rf.rsb);
        else n_pass++;
    endtask

    task automatic test_clr;
        int n;
        for (int i = 1; i < 16; i++) do_write(4'(i), 32'(i));
        rf.clr = 1'b1;
        step();
        rf.clr = 1'b0;
        n = 0;
        do begin step(); n++; end while (rf.busy === 1'b1 && n < 100);
        model_clear();
        n_total++;
        if (n != 16) $display("FAIL clr_len got %0d clocks required 16", n);
        else n_pass++;
        for (int i = 1; i < 16; i++) begin
            rf.read_rega = 4'(i); rf.read_regb = 4'(16 - i);
            step();
            n_total++;
            if (rf.rsa !== 32'd0 || rf.rsb !== 32'd0)
                $display("FAIL clr_zero addr=%0d rsa=%h rsb=%h required 0", i, rf.rsa, rf.rsb);
            else n_pass++;
        end
        // Reset in the middle of a clear restarts the full sweep.
        rf.clr = 1'b1;
        step();
        rf.clr = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        do begin step(); n++; end while (rf.busy === 1'b1 && n < 100);
        n_total++;
        if (n != 16) $display("FAIL clr_rst_restart got %0d clocks required 16", n);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [3:0]  ra, rb, wr;
        logic        sw, we;
        logic [31:0] wd, exp_a, exp_b;
        for (int it = 0; it < 200; it++) begin
            ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
            wr = 4'($urandom_range(0, 15)); sw = 1'($urandom_range(0, 3) == 0);
            we = 1'($urandom_range(0, 1)); wd = $urandom;
            rf.read_rega = ra; rf.read_regb = rb; rf.switch = sw;
            rf.rf_we = we; rf.write_reg = wr; rf.write_data = wd;
            exp_a = model_read(sw ? rb : ra, we, wr, wd);
            exp_b = model_read(rb, we, wr, wd);
            step();
            if (we && wr != 4'd0) mem[wr] = wd;
            n_total++;
            if (rf.rsa !== exp_a) $display("FAIL random_rsa it=%0d rsa=%h required %h", it, rf.rsa, exp_a);
            else n_pass++;
            n_total++;
            if (rf.rsb !== exp_b) $display("FAIL random_rsb it=%0d rsb=%h required %h", it, rf.rsb, exp_b);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_param_sweep;
        int n;
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        n = 0;
        do begin step(); n++; end while (rfs.busy === 1'b1 && n < 100);
        n_total++;
        if (n != 8) $display("FAIL sweep_clear_len got %0d clocks required 8", n);
        else n_pass++;
        rfs.rf_we = 1'b1; rfs.write_reg = 3'd7; rfs.write_data = 8'hFF;
        step();
        rfs.rf_we = 1'b0;
        rfs.read_rega = 3'd7; rfs.read_regb = 3'd7;
        step();
        n_total++;
        if (rfs.rsa !== 8'hFF || rfs.rsb !== 8'hFF)
            $display("FAIL sweep_r7 rsa=%h rsb=%h required ff", rfs.rsa, rfs.rsb);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; rst_s = 1'b1;
        idle_inputs();
        rfs.read_rega = '0; rfs.read_regb = '0; rfs.write_reg = '0;
        rfs.write_data = '0; rfs.rf_we = 1'b0; rfs.switch = 1'b0; rfs.clr = 1'b0;
        model_clear();
        test_reset();
        test_basic_rw();
        test_switch();
        test_bypass();
        test_clr();
        test_random();
        test_param_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
